// File: rtl/uart_pkg.sv
// uart_pkg
//   Definitions shared by the UART frame receiver and the future transmitter.
//   - rx_state_t : frame FSM states (IDLE, START, DATA, STOP)
//   - DATA_BITS  : payload bits per frame (8N1)
package uart_pkg;

  localparam int DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick
//   Bit-timing counter. It counts enabled cycles from zero and raises tick
//   in the cycle where the count equals the terminal value. The count then
//   wraps to zero, so each tick starts a fresh interval. clr holds the count
//   at zero, which keeps it from free-running while the receiver is idle.
// Ports
//   clk   in   1      system clock
//   rst   in   1      asynchronous active-high reset
//   clr   in   1      force the count to zero; suppresses tick
//   en    in   1      advance the count
//   term  in   CNT_W  terminal count; tick fires when count == term
//   tick  out  1      combinational interval marker
module uart_baud_tick #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             tick
);

  logic [CNT_W-1:0] cnt;

  assign tick = en && !clr && (cnt == term);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// uart_rx_frame
//   8N1 UART receiver: LSB first, line idle high. rxd is synchronised, a
//   falling edge starts a frame, and each bit is sampled near its centre.
//   A good byte goes into a one-entry valid/ready holding register.
// Ports
//   clk        in   1  system clock
//   rst        in   1  asynchronous active-high reset
//   rxd        in   1  serial input, asynchronous to clk
//   rx_data    out  8  received byte, stable while rx_valid=1
//   rx_valid   out  1  holding register occupied
//   rx_ready   in   1  consumer takes the byte when rx_valid & rx_ready
//   frame_err  out  1  one-cycle pulse: stop bit was 0, byte discarded
//   overrun    out  1  one-cycle pulse: good byte dropped, register full
//   busy       out  1  FSM not in IDLE
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int BAUD_SET_COUNTER = 1085
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 frame_err,
  output logic                 overrun,
  output logic                 busy
);

  localparam int HALF_BIT = BAUD_SET_COUNTER / 2;
  localparam int CNT_W    = $clog2(BAUD_SET_COUNTER);
  localparam int BIT_W    = $clog2(DATA_BITS);

  // The counter runs from 0 to the terminal value inclusive.
  // These terminals therefore give HALF_BIT and BAUD_SET_COUNTER cycles.
  localparam logic [CNT_W-1:0] HALF_TC  = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_TC   = CNT_W'(BAUD_SET_COUNTER - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DATA_BITS - 1);

  logic                 rxd_p0, rxd_p1, rxd_p2;
  logic                 fall;
  rx_state_t            state, state_d;
  logic                 baud_clr, baud_en, tick;
  logic [CNT_W-1:0]     term;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] rx_shift;
  logic                 shift_en, load_good, stop_bad;

  // Stage p0/p1: two-flop synchroniser. Stage p2: previous level, for edge detect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_p0 <= 1'b1;
      rxd_p1 <= 1'b1;
      rxd_p2 <= 1'b1;
    end else begin
      rxd_p0 <= rxd;
      rxd_p1 <= rxd_p0;
      rxd_p2 <= rxd_p1;
    end
  end

  assign fall = rxd_p2 && !rxd_p1;

  uart_baud_tick #(
    .CNT_W (CNT_W)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clr  (baud_clr),
    .en   (baud_en),
    .term (term),
    .tick (tick)
  );

  assign baud_en = (state != IDLE);
  assign busy    = (state != IDLE);

  // Frame FSM: state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_comb begin
    state_d   = state;
    baud_clr  = 1'b0;
    term      = BIT_TC;
    shift_en  = 1'b0;
    load_good = 1'b0;
    stop_bad  = 1'b0;
    case (state)
      IDLE: begin
        // The counter stays cleared here. A line stuck low cannot restart
        // a frame; only a fresh falling edge can.
        baud_clr = 1'b1;
        if (fall) state_d = START;
      end
      START: begin
        term = HALF_TC;
        if (tick) state_d = rxd_p1 ? IDLE : DATA;
      end
      DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) state_d = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          state_d   = IDLE;
          load_good = rxd_p1;
          stop_bad  = !rxd_p1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                bit_cnt <= '0;
    else if (state == IDLE) bit_cnt <= '0;
    else if (shift_en)      bit_cnt <= bit_cnt + BIT_W'(1);
  end

  // Bits arrive LSB first. Each new bit enters at the MSB and shifts right,
  // so the first bit ends at bit 0 after eight samples.
  always_ff @(posedge clk) begin
    if (shift_en) rx_shift <= {rxd_p1, rx_shift[DATA_BITS-1:1]};
  end

  // Holding register. It is written when empty, or when the current byte is
  // taken in this same cycle. Otherwise the old byte stays and the new one
  // is reported as an overrun.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (load_good) begin
        if (!rx_valid || rx_ready) begin
          rx_data  <= rx_shift;
          rx_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame
//   Bench for uart_rx_frame with a 16-clock bit period. Bytes the DUT should
//   deliver are queued when their frames are sent. A monitor process pops
//   and compares the queue at each handshake, and counts flag pulses.
module tb_uart_rx_frame;

  localparam int BAUD = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int n_cmp = 0;
  int n_err = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  logic fe_prev = 1'b0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  uart_rx_frame #(
    .BAUD_SET_COUNTER (BAUD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ready  (rx_ready),
    .frame_err (frame_err),
    .overrun   (overrun),
    .busy      (busy)
  );

  // Monitor: compare each delivered byte against the queue; count flag pulses.
  always @(negedge clk) begin
    logic [7:0] exp_b;
    if (!rst) begin
      if (rx_valid && rx_ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_byte: got %02h, required none", rx_data);
        end else begin
          exp_b = exp_q.pop_front();
          if (rx_data !== exp_b) begin
            n_err++;
            $display("FAIL rx_byte: got %02h, required %02h", rx_data, exp_b);
          end
        end
      end
      if (frame_err && fe_prev) begin
        n_err++;
        $display("FAIL frame_err_width: high %0d cycles, required 1", 2);
      end
      if (frame_err && overrun) begin
        n_err++;
        $display("FAIL flags_exclusive: frame_err=%b overrun=%b", frame_err, overrun);
      end
      if (frame_err) fe_cnt++;
      if (overrun)   ov_cnt++;
      fe_prev = frame_err;
    end else begin
      fe_prev = 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input logic b);
    rxd = b;
    repeat (BAUD) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
    drive_bit(stop_bit);
    rxd = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int i = 0;
    while (exp_q.size() != 0 && i < 40 * BAUD) begin
      @(negedge clk);
      i++;
    end
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    rxd      = 1'b1;
    rx_ready = 1'b1;
    idle(3);
    check("reset_rx_valid",  rx_valid,  0);
    check("reset_rx_data",   rx_data,   8'h00);
    check("reset_frame_err", frame_err, 0);
    check("reset_overrun",   overrun,   0);
    check("reset_busy",      busy,      0);
    rst = 1'b0;
    idle(10);

    // Good byte with the consumer ready.
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    idle(4);
    wait_drain("drain_a5");
    check("a5_frame_err_cnt", fe_cnt, 0);
    check("a5_overrun_cnt",   ov_cnt, 0);

    // A 4-clock low glitch is rejected at the start-bit centre.
    rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    idle(3 * BAUD);
    check("glitch_busy",     busy,     0);
    check("glitch_rx_valid", rx_valid, 0);
    check("glitch_fe_cnt",   fe_cnt,   0);

    // Bad stop bit: frame_err pulses, the byte is dropped, rx_data is unchanged.
    send_frame(8'h3C, 1'b0);
    idle(2 * BAUD);
    check("ferr_fe_cnt",   fe_cnt,   1);
    check("ferr_rx_valid", rx_valid, 0);
    check("ferr_rx_data",  rx_data,  8'hA5);
    check("ferr_ov_cnt",   ov_cnt,   0);

    // Consumer stalled: the first byte is held and the second is an overrun.
    rx_ready = 1'b0;
    exp_q.push_back(8'h11);
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    idle(2 * BAUD);
    check("ovr_rx_valid", rx_valid, 1);
    check("ovr_rx_data",  rx_data,  8'h11);
    check("ovr_ov_cnt",   ov_cnt,   1);
    check("ovr_fe_cnt",   fe_cnt,   1);
    rx_ready = 1'b1;
    wait_drain("drain_11");
    idle(2);
    check("ovr_valid_cleared", rx_valid, 0);

    // Reset in the middle of data bit 4 of 0x77.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'(8'h77 >> i));
    idle(BAUD / 2);
    rst = 1'b1;
    rxd = 1'b1;
    #1;
    check("midrst_rx_valid",  rx_valid,  0);
    check("midrst_rx_data",   rx_data,   8'h00);
    check("midrst_busy",      busy,      0);
    check("midrst_frame_err", frame_err, 0);
    check("midrst_overrun",   overrun,   0);
    idle(3);
    rst = 1'b0;
    idle(2 * BAUD);
    exp_q.push_back(8'h5A);
    send_frame(8'h5A, 1'b1);
    idle(4);
    wait_drain("drain_5a");

    // Back-to-back frames with no idle time between them.
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    idle(4);
    wait_drain("drain_b2b");
    check("final_fe_cnt", fe_cnt, 1);
    check("final_ov_cnt", ov_cnt, 1);
    check("final_busy",   busy,   0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
